conf_multichan: RTL

- AXI4-Lite slave register file for NCH independent accelerator channels, each with NREG 32-bit config registers.
- Writing a channel's register 0 launches that channel: valid/ready start handshake, then a done pulse.
- Per-channel cycle counters, sticky done status, maskable level IRQ.
- Sits between the PS general-purpose AXI port (after the interconnect's lite conversion) and the pipeline start/config inputs.

---
 rtl/conf_pkg.sv | 39 +++
 rtl/conf_channel.sv | 112 +++++++++++
 rtl/conf_multichan.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/conf_pkg.sv
// Shared definitions for the multichannel AXI4-Lite config block.
// Response codes, special word indices, FSM state types and a WSTRB merge helper.
package conf_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [9:0] IRQ_MASK_WORD = 10'd1022;
    localparam logic [9:0] IRQ_STAT_WORD = 10'd1023;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_PEND,
        CH_BUSY
    } ch_state_e;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : old[b*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/conf_channel.sv
// One accelerator channel: launch FSM, saturating cycle counter, register bank.
// Build option CONF_SHADOW_EN adds a shadow bank copied to the live bank on launch.
module conf_channel
    import conf_pkg::*;
#(
    parameter int NREG = 4,
    parameter int RW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [RW-1:0]     wr_reg,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_strb,
    input  logic [RW-1:0]     rd_reg,
    output logic [31:0]       rd_data,
    input  logic              cfg_ready,
    input  logic              cfg_done,
    output logic              cfg_valid,
    output logic              busy,
    output logic              done,
    output logic [NREG*32-1:0] live
);

    ch_state_e   state;
    ch_state_e   state_n;
    logic [31:0] cnt;
    logic [31:0] bank [NREG];
    logic        launch;
    logic        wr_ok;

    // A reg-0 write only launches from idle; the top already rejects it otherwise.
    assign launch = wr_en && (wr_reg == '0) && (state == CH_IDLE);
    assign wr_ok  = wr_en && ((wr_reg != '0) || (state == CH_IDLE));

    assign busy      = (state != CH_IDLE);
    assign cfg_valid = (state == CH_PEND);
    assign done      = (state == CH_BUSY) && cfg_done;

    // Channel state register.
    always_ff @(posedge clk) begin
        if (rst) state <= CH_IDLE;
        else     state <= state_n;
    end

    // Launch -> start handshake -> wait for completion pulse.
    always_comb begin
        state_n = state;
        unique case (state)
            CH_IDLE: if (launch)    state_n = CH_PEND;
            CH_PEND: if (cfg_ready) state_n = CH_BUSY;
            CH_BUSY: if (cfg_done)  state_n = CH_IDLE;
            default:                state_n = CH_IDLE;
        endcase
    end

    // Cycle counter: cleared on launch, counts while active, saturates.
    always_ff @(posedge clk) begin
        if (rst)                       cnt <= '0;
        else if (launch)               cnt <= '0;
        else if (busy && cnt != '1)    cnt <= cnt + 32'd1;
    end

`ifdef CONF_SHADOW_EN
    logic [31:0] shad [NREG];

    // Writes land in the shadow bank; launch snapshots it into the live bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                bank[r] <= '0;
                shad[r] <= '0;
            end
        end else if (wr_ok) begin
            if (wr_reg == '0) begin
                bank[0] <= byte_merge(bank[0], wr_data, wr_strb);
                for (int r = 1; r < NREG; r++) bank[r] <= shad[r];
            end else begin
                shad[wr_reg] <= byte_merge(shad[wr_reg], wr_data, wr_strb);
            end
        end
    end

    // Reg 0 reads the counter, others read back the shadow copy.
    always_comb begin
        rd_data = cnt;
        if (rd_reg != '0) rd_data = shad[rd_reg];
    end
`else
    // Single bank: writes go straight to the registers driving the channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) bank[r] <= '0;
        end else if (wr_ok) begin
            bank[wr_reg] <= byte_merge(bank[wr_reg], wr_data, wr_strb);
        end
    end

    // Reg 0 reads the counter, others read back the stored value.
    always_comb begin
        rd_data = cnt;
        if (rd_reg != '0) rd_data = bank[rd_reg];
    end
`endif

    // Flatten the live bank onto the channel's config bus.
    always_comb begin
        live = '0;
        for (int r = 0; r < NREG; r++) live[r*32 +: 32] = bank[r];
    end

endmodule

// File: rtl/conf_multichan.sv
// AXI4-Lite register file fronting NCH accelerator channels with launch, status and IRQ.
// Optional build macro CONF_SHADOW_EN selects shadowed channel config registers.
module conf_multichan
    import conf_pkg::*;
#(
    parameter int          NCH       = 2,
    parameter int          NREG      = 4,
    parameter logic [31:0] ADDR_BASE = 32'h0
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [31:0]              S_AXI_AWADDR,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [31:0]              S_AXI_ARADDR,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [NCH-1:0]           CONFIG_VALID,
    input  logic [NCH-1:0]           CONFIG_READY,
    input  logic [NCH-1:0]           CONFIG_DONE,
    output logic [NCH*NREG*32-1:0]   CONFIG_DATA,
    output logic                     CONFIG_IRQ
);

    localparam int         RW     = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int         CW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [9:0] NWORDS = 10'(NCH * NREG);
    localparam logic [9:0] NREG_W = 10'(NREG);

    w_state_e       w_state;
    w_state_e       w_state_n;
    r_state_e       r_state;
    r_state_e       r_state_n;

    logic [9:0]     w_word;
    logic           w_base;
    logic           w_hit_ch;
    logic           w_hit_mask;
    logic           w_hit_stat;
    logic [CW-1:0]  w_ch;
    logic [RW-1:0]  w_reg;
    logic           w_err;
    logic           wr_fire;
    logic           w_ok;

    logic [9:0]     r_word;
    logic           r_base;
    logic [CW-1:0]  r_ch;
    logic [RW-1:0]  r_reg;
    logic           rd_fire;
    logic [31:0]    rd_val;
    logic           rd_err;

    logic [NCH-1:0] ch_busy;
    logic [NCH-1:0] ch_done;
    logic [31:0]    ch_rd [NCH];
    logic [NCH-1:0] irq_mask;
    logic [NCH-1:0] status;
    logic [NCH-1:0] stat_clr;
    logic [31:0]    mask_merged;
    logic [31:0]    clr_merged;
    logic [1:0]     bresp;
    logic [31:0]    rdata;
    logic [1:0]     rresp;
    logic           unused_ok;

    assign unused_ok = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         mask_merged[31:NCH], clr_merged[31:NCH]};

    // Write address decode.
    assign w_word     = S_AXI_AWADDR[11:2];
    assign w_base     = (S_AXI_AWADDR[31:12] == ADDR_BASE[31:12]);
    assign w_hit_ch   = w_base && (w_word < NWORDS);
    assign w_hit_mask = w_base && (w_word == IRQ_MASK_WORD);
    assign w_hit_stat = w_base && (w_word == IRQ_STAT_WORD);
    assign w_ch       = CW'(w_word / NREG_W);
    assign w_reg      = RW'(w_word % NREG_W);
    assign w_err      = !(w_hit_ch || w_hit_mask || w_hit_stat)
                      || (w_hit_ch && (w_reg == '0) && ch_busy[w_ch]);

    // AW and W are accepted together, one write outstanding.
    assign wr_fire       = !ARESET && (w_state == W_IDLE)
                         && S_AXI_AWVALID && S_AXI_WVALID;
    assign w_ok          = wr_fire && !w_err;
    assign S_AXI_AWREADY = wr_fire;
    assign S_AXI_WREADY  = wr_fire;
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = bresp;

    // Write channel state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_state_n;
    end

    // Accept, then hold the response until the master takes it.
    always_comb begin
        w_state_n = w_state;
        unique case (w_state)
            W_IDLE:  if (wr_fire)      w_state_n = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_state_n = W_IDLE;
            default:                   w_state_n = W_IDLE;
        endcase
    end

    // Capture the write response at accept time.
    always_ff @(posedge ACLK) begin
        if (ARESET)       bresp <= RESP_OKAY;
        else if (wr_fire) bresp <= w_err ? RESP_SLVERR : RESP_OKAY;
    end

    // Read address decode and data select.
    assign r_word = S_AXI_ARADDR[11:2];
    assign r_base = (S_AXI_ARADDR[31:12] == ADDR_BASE[31:12]);
    assign r_ch   = CW'(r_word / NREG_W);
    assign r_reg  = RW'(r_word % NREG_W);

    // Pick the read source; unmapped words return zero with an error.
    always_comb begin
        rd_val = '0;
        rd_err = 1'b1;
        if (r_base && (r_word < NWORDS)) begin
            rd_val = ch_rd[r_ch];
            rd_err = 1'b0;
        end else if (r_base && (r_word == IRQ_MASK_WORD)) begin
            rd_val = 32'(irq_mask);
            rd_err = 1'b0;
        end else if (r_base && (r_word == IRQ_STAT_WORD)) begin
            rd_val = 32'(status);
            rd_err = 1'b0;
        end
    end

    assign rd_fire       = !ARESET && (r_state == R_IDLE) && S_AXI_ARVALID;
    assign S_AXI_ARREADY = !ARESET && (r_state == R_IDLE);
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;

    // Read channel state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_state_n;
    end

    // Accept an address, then hold data until the master takes it.
    always_comb begin
        r_state_n = r_state;
        unique case (r_state)
            R_IDLE:  if (rd_fire)      r_state_n = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_n = R_IDLE;
            default:                   r_state_n = R_IDLE;
        endcase
    end

    // Register read data and response on accept.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else if (rd_fire) begin
            rdata <= rd_val;
            rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    assign mask_merged = byte_merge(32'(irq_mask), S_AXI_WDATA, S_AXI_WSTRB);
    assign clr_merged  = byte_merge(32'h0, S_AXI_WDATA, S_AXI_WSTRB);
    assign stat_clr    = (w_ok && w_hit_stat) ? clr_merged[NCH-1:0] : '0;

    // IRQ mask register.
    always_ff @(posedge ACLK) begin
        if (ARESET)                  irq_mask <= '0;
        else if (w_ok && w_hit_mask) irq_mask <= mask_merged[NCH-1:0];
    end

    // Sticky done status; a same-cycle completion beats a clear.
    always_ff @(posedge ACLK) begin
        if (ARESET) status <= '0;
        else        status <= (status & ~stat_clr) | ch_done;
    end

    assign CONFIG_IRQ = |(status & irq_mask);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        conf_channel #(
            .NREG (NREG),
            .RW   (RW)
        ) u_ch (
            .clk       (ACLK),
            .rst       (ARESET),
            .wr_en     (w_ok && w_hit_ch && (w_ch == CW'(c))),
            .wr_reg    (w_reg),
            .wr_data   (S_AXI_WDATA),
            .wr_strb   (S_AXI_WSTRB),
            .rd_reg    (r_reg),
            .rd_data   (ch_rd[c]),
            .cfg_ready (CONFIG_READY[c]),
            .cfg_done  (CONFIG_DONE[c]),
            .cfg_valid (CONFIG_VALID[c]),
            .busy      (ch_busy[c]),
            .done      (ch_done[c]),
            .live      (CONFIG_DATA[c*NREG*32 +: NREG*32])
        );
    end

endmodule
